// File: rtl/io_event_unit_pkg.sv
// io_event_unit shared definitions:
// register map, field positions, reset values.
package io_event_pkg;

  localparam int unsigned A_MS   = 0;
  localparam int unsigned A_BTN  = 1;
  localparam int unsigned A_EVT  = 2;
  localparam int unsigned A_STAT = 3;
  localparam int unsigned A_CTRL = 4;
  localparam int unsigned A_CMP  = 5;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;
  localparam int ST_MATCH = 11;

  localparam int CT_IRQ  = 0;
  localparam int CT_CAPP = 1;
  localparam int CT_CAPR = 2;

  localparam int EV_VALID  = 31;
  localparam int EV_PRESS  = 30;
  localparam int EV_CH_LSB = 16;
  localparam int EV_TS_LSB = 0;

  localparam logic [2:0]  CTRL_RST = 3'b110;
  localparam logic [31:0] CMP_RST  = 32'hFFFF_FFFF;

  // Pack one FIFO event word.
  function automatic logic [31:0] ev_word(
    input logic        press,
    input logic [7:0]  ch,
    input logic [15:0] ts
  );
    logic [31:0] w;
    w = '0;
    w[EV_VALID] = 1'b1;
    w[EV_PRESS] = press;
    w[EV_CH_LSB +: 8] = ch;
    w[EV_TS_LSB +: 16] = ts;
    return w;
  endfunction

endpackage

// File: rtl/io_event_unit_if.sv
// io_event_unit bus: word-addressed
// read/write port from the memory decoder.
interface io_event_unit_if #(
  parameter int ADDR_BITS = 11
);
  logic                 en;
  logic                 we;
  logic [ADDR_BITS-1:0] addr;
  logic [31:0]          wd;
  logic [31:0]          rd;

  modport master (
    output en, we, addr, wd,
    input  rd
  );

  modport slave (
    input  en, we, addr, wd,
    output rd
  );
endinterface

// File: rtl/io_event_unit_btn_debounce.sv
// One button channel: 2-flop sync, tick-
// sampled debounce counter, flip pulse.
module btn_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic tick_i,
  output logic lvl_o,
  output logic flip_o
);
  localparam int CNTW = 4;

  logic            s1_q, s2_q;
  logic            stab_q, stab_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Synchroniser for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

  // Count ticks a differing level persists.
  always_comb begin
    stab_d = stab_q;
    cnt_d  = cnt_q;
    flip_o = 1'b0;
    if (tick_i) begin
      if (s2_q != stab_q) begin
        if (cnt_q == CNTW'(DEB_TICKS - 1)) begin
          stab_d = ~stab_q;
          cnt_d  = '0;
          flip_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Stable state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      stab_q <= stab_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lvl_o = stab_q;

endmodule

// File: rtl/io_event_unit.sv
// Memory-mapped ms timer, debounced buttons
// and timestamped press/release event FIFO.
module io_event_unit
  import io_event_pkg::*;
#(
  parameter int DIV        = 50000,
  parameter int NBTN       = 8,
  parameter int DEB_TICKS  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_BITS  = 11
) (
  input  logic            clk,
  input  logic            rst,
  io_event_unit_if.slave  bus,
  input  logic [NBTN-1:0] btn,
  output logic            irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(DIV);

  logic wr, rdn;
  logic hit_ms, hit_btn, hit_evt;
  logic hit_stat, hit_ctrl, hit_cmp;

  assign wr  = bus.en & bus.we;
  assign rdn = bus.en & ~bus.we;

  assign hit_ms   = bus.addr == ADDR_BITS'(A_MS);
  assign hit_btn  = bus.addr == ADDR_BITS'(A_BTN);
  assign hit_evt  = bus.addr == ADDR_BITS'(A_EVT);
  assign hit_stat = bus.addr == ADDR_BITS'(A_STAT);
  assign hit_ctrl = bus.addr == ADDR_BITS'(A_CTRL);
  assign hit_cmp  = bus.addr == ADDR_BITS'(A_CMP);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   ms_q, ms_d;
  logic          tick, match_set;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [31:0]   cmp_q, cmp_d;
  logic          ovf_q, ovf_d;
  logic          match_q, match_d;
  logic          ovf_set;

  assign tick = presc_q == PW'(DIV - 1);

  // Prescaler, ms counter and compare detect.
  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    ms_d      = ms_q;
    match_set = 1'b0;
    if (wr && hit_ms) begin
      ms_d    = bus.wd;
      presc_d = '0;
    end else if (tick) begin
      ms_d      = ms_q + 32'd1;
      match_set = (ms_q + 32'd1) == cmp_q;
    end
  end

  // Timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
    end
  end

  logic [NBTN-1:0] lvl, flip;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    btn_debounce #(
      .DEB_TICKS(DEB_TICKS)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn[g]),
      .tick_i (tick),
      .lvl_o  (lvl[g]),
      .flip_o (flip[g])
    );
  end

  logic [NBTN-1:0] pend_q, pend_d;
  logic [NBTN-1:0] pdir_q, pdir_d;
  logic            has_pend;
  logic [7:0]      psel;
  logic            pdir_sel;

  assign has_pend = |pend_q;

  // Lowest-index pending channel wins.
  always_comb begin
    psel     = '0;
    pdir_sel = 1'b0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        psel     = 8'(i);
        pdir_sel = pdir_q[i];
      end
    end
  end

  // Clear the pushed flag; new flips win.
  always_comb begin
    pend_d = pend_q;
    pdir_d = pdir_q;
    for (int i = 0; i < NBTN; i++) begin
      if (has_pend && psel == 8'(i)) begin
        pend_d[i] = 1'b0;
      end
      if (flip[i] && (lvl[i] ? ctrl_q[CT_CAPR]
                             : ctrl_q[CT_CAPP])) begin
        pend_d[i] = 1'b1;
        pdir_d[i] = ~lvl[i];
      end
    end
  end

  // Pending flags and captured direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      pdir_q <= '0;
    end else begin
      pend_q <= pend_d;
      pdir_q <= pdir_d;
    end
  end

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full, pop, push;

  assign empty   = cnt_q == '0;
  assign full    = cnt_q == CW'(FIFO_DEPTH);
  assign pop     = rdn & hit_evt & ~empty;
  assign push    = has_pend & (~full | pop);
  assign ovf_set = has_pend & full & ~pop;

  // FIFO pointers and occupancy.
  always_comb begin
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // FIFO control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage; validity comes from cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= ev_word(pdir_sel, psel,
                             ms_q[15:0]);
    end
  end

  // Control/compare writes and sticky flags.
  always_comb begin
    ctrl_d  = ctrl_q;
    cmp_d   = cmp_q;
    ovf_d   = ovf_q;
    match_d = match_q;
    if (wr && hit_ctrl) ctrl_d = bus.wd[2:0];
    if (wr && hit_cmp) cmp_d = bus.wd;
    if (wr && hit_stat) begin
      if (bus.wd[ST_OVF]) ovf_d = 1'b0;
      if (bus.wd[ST_MATCH]) match_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (match_set) match_d = 1'b1;
  end

  // Control/status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= CTRL_RST;
      cmp_q   <= CMP_RST;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      cmp_q   <= cmp_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
    end
  end

  logic [31:0] rd_q, rd_d;
  logic [31:0] stat_w, btn_w;

  // Read mux; rd holds between reads.
  always_comb begin
    stat_w = '0;
    stat_w[7:0] = 8'(cnt_q);
    stat_w[ST_EMPTY] = empty;
    stat_w[ST_FULL]  = full;
    stat_w[ST_OVF]   = ovf_q;
    stat_w[ST_MATCH] = match_q;
    btn_w = '0;
    btn_w[NBTN-1:0] = lvl;
    rd_d = rd_q;
    if (rdn) begin
      unique case (1'b1)
        hit_ms:   rd_d = ms_q;
        hit_btn:  rd_d = btn_w;
        hit_evt:  rd_d = empty ? '0 : mem_q[rp_q];
        hit_stat: rd_d = stat_w;
        hit_ctrl: rd_d = {29'b0, ctrl_q};
        hit_cmp:  rd_d = cmp_q;
        default:  rd_d = '0;
      endcase
    end
  end

  // Registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign bus.rd = rd_q;
  assign irq = ctrl_q[CT_IRQ] & (~empty | match_q);

endmodule

// File: tb/tb_io_event_unit.sv
// io_event_unit bench: directed scenarios plus
// random traffic against a behavioural model.
module tb_io_event_unit;
  localparam int DIV   = 4;
  localparam int NBTN  = 8;
  localparam int DEB   = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn_r;
  logic       irq;
  int         n_err = 0;
  int         n_chk = 0;

  io_event_unit_if #(.ADDR_BITS(11)) bif ();

  io_event_unit #(
    .DIV(DIV), .NBTN(NBTN), .DEB_TICKS(DEB),
    .FIFO_DEPTH(DEPTH), .ADDR_BITS(11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave),
    .btn (btn_r),
    .irq (irq)
  );

  always #5 clk = ~clk;

  // Reference model state.
  longint      m_el;
  logic [31:0] m_ld, m_cmp, m_rd;
  logic [2:0]  m_ctrl;
  bit          m_match, m_ovf;
  logic [31:0] m_q[$];
  logic [7:0]  m_h1, m_h2, m_stab;
  int          m_cnt [NBTN];
  bit          m_pend [NBTN];
  bit          m_pdir [NBTN];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_ms();
    return m_ld + 32'(m_el / DIV);
  endfunction

  function automatic logic [31:0] m_stat();
    int s;
    s = m_q.size();
    return {20'b0, m_match, m_ovf, s == DEPTH,
            s == 0, 8'(s)};
  endfunction

  function automatic logic m_irq();
    return m_ctrl[0] & ((m_q.size() > 0) | m_match);
  endfunction

  task automatic model_reset();
    m_el = 0; m_ld = 0; m_cmp = '1; m_rd = 0;
    m_ctrl = 3'b110; m_match = 0; m_ovf = 0;
    m_q.delete();
    m_h1 = 0; m_h2 = 0; m_stab = 0;
    for (int i = 0; i < NBTN; i++) begin
      m_cnt[i] = 0; m_pend[i] = 0; m_pdir[i] = 0;
    end
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_edge(input logic en, we,
                            input logic [10:0] a,
                            input logic [31:0] d,
                            input logic [7:0] b);
    logic [31:0] cur;
    logic [2:0]  c0;
    bit pop, tick, oset, mset;
    int k;
    cur = m_ms(); c0 = m_ctrl;
    pop = 0; oset = 0; mset = 0;
    if (en && !we) begin
      case (a)
        11'd0: m_rd = cur;
        11'd1: m_rd = {24'b0, m_stab};
        11'd2: begin
          if (m_q.size() > 0) begin
            m_rd = m_q[0]; pop = 1;
          end else m_rd = 0;
        end
        11'd3: m_rd = m_stat();
        11'd4: m_rd = {29'b0, m_ctrl};
        11'd5: m_rd = m_cmp;
        default: m_rd = 0;
      endcase
    end
    if (pop) void'(m_q.pop_front());
    k = -1;
    for (int i = NBTN - 1; i >= 0; i--)
      if (m_pend[i]) k = i;
    if (k >= 0) begin
      m_pend[k] = 0;
      if (m_q.size() < DEPTH)
        m_q.push_back({1'b1, m_pdir[k], 6'b0,
                       8'(k), cur[15:0]});
      else oset = 1;
    end
    tick = ((m_el + 1) % DIV) == 0;
    if (en && we && a == 11'd0) begin
      m_ld = d; m_el = 0;
    end else begin
      m_el++;
      if (tick && m_ms() == m_cmp) mset = 1;
    end
    for (int i = 0; i < NBTN; i++) begin
      if (tick) begin
        if (m_h2[i] != m_stab[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin
            m_stab[i] = ~m_stab[i];
            m_cnt[i] = 0;
            if (m_stab[i] ? c0[1] : c0[2]) begin
              m_pend[i] = 1;
              m_pdir[i] = m_stab[i];
            end
          end
        end else m_cnt[i] = 0;
      end
    end
    m_h2 = m_h1; m_h1 = b;
    if (en && we) begin
      case (a)
        11'd3: begin
          if (d[10]) m_ovf = 0;
          if (d[11]) m_match = 0;
        end
        11'd4: m_ctrl = d[2:0];
        11'd5: m_cmp = d;
        default: ;
      endcase
    end
    if (oset) m_ovf = 1;
    if (mset) m_match = 1;
  endtask

  task automatic step(input logic en, we,
                      input logic [10:0] a,
                      input logic [31:0] d);
    bif.en = en; bif.we = we;
    bif.addr = a; bif.wd = d;
    model_edge(en, we, a, d, btn_r);
    @(posedge clk);
    @(negedge clk);
    check("rd", bif.rd, m_rd);
    check("irq", {31'b0, irq}, {31'b0, m_irq()});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic rd_reg(input logic [10:0] a);
    step(1, 0, a, 0);
  endtask

  task automatic wr_reg(input logic [10:0] a,
                        input logic [31:0] d);
    step(1, 1, a, d);
  endtask

  initial begin
    int bi, op;
    rst = 1'b1; btn_r = 0;
    bif.en = 0; bif.we = 0;
    bif.addr = 0; bif.wd = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_rd", bif.rd, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b0;

    idle(40);
    rd_reg(0);
    check("ms40", bif.rd, 32'd10);
    wr_reg(0, 32'hFFFF_FFFF);
    idle(4);
    rd_reg(0);
    check("ms_wrap", bif.rd, 32'd0);

    btn_r[3] = 1'b1;
    idle(22);
    rd_reg(1);
    check("btn3", bif.rd, 32'h08);
    rd_reg(2);
    check("evt3", {16'b0, bif.rd[31:16]}, 32'hC003);
    rd_reg(2);
    check("evt_empty", bif.rd, 32'd0);

    btn_r[1] = 1'b1;
    idle(8);
    btn_r[1] = 1'b0;
    idle(30);
    rd_reg(1);
    check("glitch_btn", bif.rd, 32'h08);
    rd_reg(2);
    check("glitch_evt", bif.rd, 32'd0);

    btn_r = btn_r | 8'h21;
    idle(25);
    rd_reg(2);
    check("pair_0", {16'b0, bif.rd[31:16]}, 32'hC000);
    rd_reg(2);
    check("pair_5", {16'b0, bif.rd[31:16]}, 32'hC005);

    btn_r = ~btn_r;
    idle(25);
    btn_r[0] = ~btn_r[0];
    idle(25);
    rd_reg(3);
    check("ovf_stat", {20'b0, bif.rd[11:0]}, 32'h608);
    wr_reg(3, 32'h400);
    rd_reg(3);
    check("ovf_w1c", {20'b0, bif.rd[11:0]}, 32'h208);
    for (int i = 0; i < 8; i++) rd_reg(2);
    rd_reg(3);
    check("drained", {20'b0, bif.rd[11:0]}, 32'h100);

    wr_reg(4, 32'h1);
    wr_reg(5, 32'd5);
    wr_reg(0, 32'd0);
    idle(22);
    check("irq_match", {31'b0, irq}, 32'd1);
    wr_reg(3, 32'h800);
    check("irq_w1c", {31'b0, irq}, 32'd0);
    idle(5);
    #2 rst = 1'b1;
    #1 model_reset();
    check("mid_rst_irq", {31'b0, irq}, 32'd0);
    check("mid_rst_rd", bif.rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_reg(0);
    check("mid_rst_ms", bif.rd, 32'd0);

    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        bi = $urandom_range(0, 7);
        btn_r[bi] = ~btn_r[bi];
      end
      op = $urandom_range(0, 19);
      if (op < 10) idle(1);
      else if (op < 16)
        rd_reg(11'($urandom_range(0, 7)));
      else if (op == 16) wr_reg(3, $urandom);
      else if (op == 17)
        wr_reg(4, {29'b0, 3'($urandom)});
      else if (op == 18)
        wr_reg(5, m_ms() + $urandom_range(1, 3));
      else if ($urandom_range(0, 3) == 0)
        wr_reg(0, $urandom);
      else
        wr_reg(11'($urandom_range(6, 2047)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/io_event_unit.md
# io_event_unit

Parametrised memory-mapped I/O peripheral that generalises the single-cycle SoC's millisecond counter and button port. It provides a loadable millisecond timer with a compare flag, NBTN debounced button channels, and a timestamped press/release event FIFO with an interrupt output. It occupies the IO slot of the memory decoder: enabled by its `mE` bit and addressed with word address `pAd[12:2]`.

## Interface
- `DIV`, 50000: clk cycles per millisecond tick; ≥2.
- `NBTN`, 8: button channels; 1..32.
- `DEB_TICKS`, 4: consecutive ms ticks a new level must persist before it is accepted; 1..15.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, 2..128.
- `ADDR_BITS`, 11: word-address width.

Ports:
- `clk`  in  1  system clock (cclk domain).
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  block select from the memory decoder.
- `we`  in  1  write strobe; any bit of `owe` set counts as a write. Writes are whole-word.
- `addr`  in  ADDR_BITS  word address.
- `wd`  in  32  write data.
- `rd`  out  32  registered read data.
- `btn`  in  NBTN  raw active-high buttons; asynchronous.
- `irq`  out  1  level interrupt.

## Operation
Register map (word address; unmapped addresses read 0 and ignore writes):
- 0 MS: R = ms counter. W loads the counter and clears the prescaler.
- 1 BTN: R = debounced state, zero-extended.
- 2 EVT: R pops one event. The word is: bit31 valid=1, bit30 press(1)/release(0), [23:16] channel index, [15:0] ms[15:0] at push time. When the FIFO is empty, R returns 0 and does not pop.
- 3 STAT: [7:0] count, bit8 empty, bit9 full, bit10 overflow (sticky), bit11 match (sticky). W1C on bits 10 and 11.
- 4 CTRL: bit0 irq_en, bit1 cap_press, bit2 cap_release. R/W. Reset value 0x6.
- 5 CMP: compare value. R/W. Reset value 0xFFFFFFFF.

Timer:
- The prescaler counts 0..DIV-1. A tick fires on the cycle the prescaler equals DIV-1, and the prescaler then returns to 0.
- ms increments on each tick and wraps from 0xFFFFFFFF to 0.
- match is set on the cycle ms transitions to a value equal to CMP.
- A load to MS does not set match, even when the loaded value equals CMP.

Debounce (per channel):
- A 2-flop synchroniser feeds a level sampled on each tick.
- When the sampled level differs from the stable state, the channel counter increments; otherwise it clears.
- When the counter reaches DEB_TICKS, the stable state flips, the counter clears, and a pending flag is set if the matching cap bit is enabled.

Event push:
- At most one push per cycle: the lowest-index pending channel is pushed and its flag cleared.
- Push when full (and no pop in the same cycle): the event is dropped, overflow is set, and the pending flag is cleared.
- Push and pop in the same cycle: both happen and count is unchanged. A push into a full FIFO succeeds if a pop occurs in the same cycle.
- irq = irq_en & (!empty | match).

## Timing
- Reset values: rd=0, irq=0, ms=0, prescaler=0, debounced state=0, counters=0, pending=0, FIFO empty, overflow=0, match=0, CTRL=0x6, CMP=0xFFFFFFFF.
- Read latency is 1 clk. `rd` updates at the posedge where en & !we and holds until the next read. The pop and the `rd` capture happen at the same edge.
- Writes take effect at the posedge where en & we; a read of the same register on the next cycle returns the new value.
- Button latency:
  - Sync: 2 clk.
  - Debounce: the first tick after the change plus DEB_TICKS−1 further ticks.
  - The push happens on the clk after the pending flag is set.
- A W1C and a new match/overflow set in the same cycle: the set wins.
- Reset asserted mid-operation clears all state immediately, including pending events.

## Structure
- Package io_event_pkg holds:
  - Register address constants.
  - STAT/CTRL bit positions.
  - Event field positions.
  - CTRL reset value.
- Sub-module btn_debounce (synchroniser, counter, stable state, edge pulse) is instantiated NBTN times via generate.
- The FIFO, timer and register file are inline in io_event_unit.

## Test plan
- DIV=4: release rst and hold 40 clk, then read MS → 10. Write MS=0xFFFFFFFF, wait 4 clk, read → 0.
- DEB_TICKS=4, DIV=4: btn[3] 0→1, held stable. BTN reads 0x08 within 2+16+1 clk. EVT reads 0xC003xxxx (timestamp = ms at push). A second EVT read returns 0.
- Glitch: btn[1] high for 2 ticks, then low → no event, BTN stays 0.
- btn[0] and btn[5] flip in the same clk → two events, channel 0 first then 5, on consecutive cycles.
- FIFO_DEPTH=8: generate 9 events without reading.
  - STAT reads full=1, count=8, overflow=1.
  - Write STAT=0x400 → overflow=0.
  - Pop 8 → empty=1.
- CTRL=0x1, CMP=5, DIV=4: irq rises when ms becomes 5. Write STAT=0x800 → irq=0. Reset mid-count → irq=0, ms=0.
